// File: rtl/lambda_search_ctrl_if.sv
// lambda_search_ctrl_if: handshake and result bus of the lambda search controller.
// Ports (controller view, slave modport):
//   i_start, i_abort           window request / synchronous cancel
//   i_sample_valid, o_sample_ready   upstream sample handshake
//   i_lambda_in                signed lambda from the datapath output
//   o_busy, o_done             status and one-cycle completion pulse
//   o_best_idx, o_best_lambda  argmax index and value of the last window
interface lambda_search_ctrl_if #(
    parameter int IDX_W    = 6,
    parameter int LAMBDA_W = 14
);
    logic                       i_start;
    logic                       i_abort;
    logic                       i_sample_valid;
    logic                       o_sample_ready;
    logic signed [LAMBDA_W-1:0] i_lambda_in;
    logic                       o_busy;
    logic                       o_done;
    logic [IDX_W-1:0]           o_best_idx;
    logic signed [LAMBDA_W-1:0] o_best_lambda;

    modport master (
        output i_start, i_abort, i_sample_valid, i_lambda_in,
        input  o_sample_ready, o_busy, o_done, o_best_idx, o_best_lambda
    );

    modport slave (
        input  i_start, i_abort, i_sample_valid, i_lambda_in,
        output o_sample_ready, o_busy, o_done, o_best_idx, o_best_lambda
    );
endinterface

// File: rtl/lambda_search_ctrl.sv
// lambda_search_ctrl: window sequencer and argmax tracker for the lambda datapath.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      lambda_search_ctrl_if.slave (start/abort, sample handshake,
//            lambda input, busy/done, best index and value)
module lambda_search_ctrl #(
    parameter int WIN_LEN  = 64,
    parameter int IDX_W    = $clog2(WIN_LEN),
    parameter int DP_LAT   = 6,
    parameter int LAMBDA_W = 14
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    lambda_search_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_REPORT} state_t;

    localparam logic [IDX_W:0] L_WIN = (IDX_W + 1)'(WIN_LEN);

    state_t                     r_state, w_next;
    logic [DP_LAT-1:0]          r_vpipe;
    logic [IDX_W:0]             r_issue_cnt, r_res_cnt, w_issue_inc, w_res_inc;
    logic signed [LAMBDA_W-1:0] r_max, r_best_lambda;
    logic [IDX_W-1:0]           r_max_idx, r_best_idx;
    logic                       r_first;
    logic                       w_accept, w_res_valid, w_take, w_report, w_clear;

    always_comb begin
        w_issue_inc = r_issue_cnt + 1'b1;
        w_res_inc   = r_res_cnt + 1'b1;
        w_accept    = bus.i_sample_valid && r_state == S_FEED;
        // last valid-pipe stage is cycle-aligned with i_lambda_in
        w_res_valid = r_vpipe[DP_LAT-1];
        w_take      = w_res_valid && (r_state == S_FEED || r_state == S_DRAIN);
        w_report    = r_state == S_REPORT && !bus.i_abort;
        w_clear     = r_state == S_IDLE && bus.i_start;
        w_next      = r_state;
        case (r_state)
            S_IDLE:   w_next = bus.i_start ? S_FEED : S_IDLE;
            S_FEED:   w_next = (w_accept && w_issue_inc == L_WIN) ? S_DRAIN : S_FEED;
            // leave on the cycle the final result arrives so done lands one cycle later
            S_DRAIN:  w_next = (w_res_valid && w_res_inc == L_WIN) ? S_REPORT : S_DRAIN;
            default:  w_next = S_IDLE;
        endcase
        if (bus.i_abort) w_next = S_IDLE;
    end

    assign bus.o_sample_ready = r_state == S_FEED;
    assign bus.o_busy         = r_state != S_IDLE;
    assign bus.o_done         = w_report;
    // best_* show the new result already in the REPORT cycle, unless aborted
    assign bus.o_best_idx     = w_report ? r_max_idx : r_best_idx;
    assign bus.o_best_lambda  = w_report ? r_max : r_best_lambda;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_vpipe       <= '0;
            r_issue_cnt   <= '0;
            r_res_cnt     <= '0;
            r_max         <= '0;
            r_max_idx     <= '0;
            r_first       <= 1'b0;
            r_best_idx    <= '0;
            r_best_lambda <= '0;
        end else begin
            r_state    <= w_next;
            r_vpipe[0] <= w_accept && !bus.i_abort;
            for (int i = 1; i < DP_LAT; i++) r_vpipe[i] <= bus.i_abort ? 1'b0 : r_vpipe[i-1];
            if (bus.i_abort || w_clear) begin
                r_issue_cnt <= '0;
                r_res_cnt   <= '0;
            end else begin
                if (w_accept) r_issue_cnt <= w_issue_inc;
                if (w_take) r_res_cnt <= w_res_inc;
            end
            // strict greater-than keeps the earliest index on ties
            if (w_clear) begin
                r_max     <= '0;
                r_max_idx <= '0;
                r_first   <= 1'b1;
            end else if (w_take && (r_first || bus.i_lambda_in > r_max)) begin
                r_max     <= bus.i_lambda_in;
                r_max_idx <= r_res_cnt[IDX_W-1:0];
                r_first   <= 1'b0;
            end
            if (w_report) begin
                r_best_idx    <= r_max_idx;
                r_best_lambda <= r_max;
            end
        end
    end
endmodule

// File: doc/lambda_search_ctrl.md
# lambda_search_ctrl

Sequencer and argmax tracker for the lambda datapath (lambda = mag − rho·phi, fixed 6-register latency, no enable). The block accepts one search window of WIN_LEN samples from the upstream correlator under a valid/ready handshake. It tags each accepted sample through a valid shadow pipe matched to the datapath latency. It scans the returned lambda stream for its maximum and reports the winning sample index (the timing-offset estimate) with a one-cycle done pulse. It sits between the correlator front end and the CFO/timing correction stage.

## Interface
- WIN_LEN, 64: samples per search window (≥2).
- IDX_W, 6: index width, $clog2(WIN_LEN).
- DP_LAT, 6: lambda datapath latency in cycles. Must equal the datapath's delay-line depth.
- LAMBDA_W, 14: lambda width, signed Q6.8.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to search a window. Honoured only in IDLE.
- abort  in  1  synchronous cancel. Honoured in any state.
- sample_valid  in  1  upstream mag/phi/rho presented this cycle.
- sample_ready  out  1  controller consumes the sample this cycle.
- lambda_in  in  LAMBDA_W  signed lambda from the datapath output.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; best_* are valid from this cycle on.
- best_idx  out  IDX_W  index (0-based, acceptance order) of the maximum lambda.
- best_lambda  out  LAMBDA_W  maximum lambda value, signed.

## Operation
- Reset values: sample_ready=0, busy=0, done=0, best_idx=0, best_lambda=0. The valid pipe, counters, and running max are cleared, and the state is IDLE.
- Accept = sample_valid & sample_ready. Upstream holds mag/phi/rho stable only on accept cycles. Non-accepted inputs still flow through the datapath, but they are tagged invalid and ignored.
- Valid pipe: a DP_LAT-deep shift register. Stage 0 loads accept every cycle. res_valid = the last stage, which is cycle-aligned with lambda_in.
- States:
  - IDLE: sample_ready=0. start=1 → FEED. This transition clears issue_cnt, res_cnt, the running max, and the first flag.
  - FEED: sample_ready=1. Each accept increments issue_cnt. The accept that brings issue_cnt to WIN_LEN moves the block to DRAIN on the same edge.
  - DRAIN: sample_ready=0. The block waits until res_cnt reaches WIN_LEN, then goes to REPORT.
  - REPORT: one cycle. done=1, best_idx and best_lambda are loaded from the running max, then the block returns to IDLE.
- Result handling: the block processes results in FEED and DRAIN whenever res_valid=1.
  - The first result of a window loads the running max unconditionally, with index 0.
  - A later result replaces the max only if $signed(lambda_in) > running max (strict). Ties keep the earliest index.
  - res_cnt increments on every valid result and supplies the index.
- Signed compare only: 14'h2000 (−32.0) is the minimum value, 14'h1FFF the maximum.
- best_idx and best_lambda change only in REPORT. They hold their values across IDLE, later windows, and abort.
- start while busy is ignored (no queueing).
- abort=1:
  - The block goes to IDLE on the next edge and clears the valid pipe and the counters.
  - done is not asserted, and best_* are unchanged.
  - abort takes priority over start and over REPORT in the same cycle. If abort arrives in REPORT, done is suppressed and best_* are not updated.
- Asynchronous reset mid-window: the block returns to the reset values immediately, and in-flight datapath results are discarded because the pipe is cleared.
- Counters are IDX_W+1 bits, so issue_cnt and res_cnt can hold WIN_LEN without wrapping.

## Timing
- start high in cycle 0 → FEED and sample_ready=1 from cycle 1.
- A sample accepted in cycle c has res_valid and its lambda on lambda_in in cycle c+DP_LAT.
- The last accept in cycle c gives REPORT and done=1 in cycle c+DP_LAT+1. best_* show the new values from that cycle on.
- Back-to-back window, WIN_LEN=64, sample_valid held high:
  - accepts in cycles 1..64;
  - sample_ready falls in cycle 65;
  - results in cycles 7..70;
  - done in cycle 71;
  - busy high in cycles 1..71, low in cycle 72.
- Upstream stalls (sample_valid low) only lengthen FEED. Result indices are unaffected.
- Earliest new start: the cycle after done (cycle 72), which gives a new FEED in cycle 73.

## Test plan
- Ramp: reset, start, 64 back-to-back samples with lambda_in = index (Q6.8 values 0..63) → done in cycle 71, best_idx=63, best_lambda=14'd63.
- Single negative peak: all lambda=14'h2000 (−32.0) except index 17 = 14'h3F00 (−1.0) → best_idx=17, best_lambda=14'h3F00. This checks the signed compare.
- Tie: lambda=14'h0100 at indices 5 and 40, all others 14'h0000 → best_idx=5 (earliest wins).
- Bubbles: sample_valid low every third cycle while the non-accepted lambda is driven to 14'h1FFF → no bubble value is selected, indices stay contiguous, and done comes DP_LAT+1 cycles after the 64th accept.
- Abort: abort in DRAIN, then start and a full window of all-zero lambda → no done for the aborted window, best_* hold the previous values until the next done, then best_idx=0, best_lambda=0.
- Reset and ignored start: drive rst low mid-FEED → outputs go to zero at once. Pulse start while busy → no extra window and exactly one done.
